// File: rtl/spi_shifter.sv
// spi_shifter -- SPI master data path: serialises a TX word onto MOSI and
// assembles a word from MISO. SCK edges come from an external clock
// generator as one-cycle flags; this block tells that generator when to
// run (O_GO) and when the final SCK period is in progress (O_LAST_CLK).
//
// Ports
//   I_SYS_CLK     system clock, all logic on the rising edge
//   I_RST         synchronous active-high reset
//   I_EN          block enable; dropping it aborts a transfer
//   I_CPOL/I_CPHA SPI mode, captured at transfer start
//   I_LSB_FIRST   bit order, captured at transfer start
//   I_START       one-cycle start request, loads I_TX_DATA
//   I_TX_DATA     transmit word
//   I_POS_EGDE    SCK rising-edge flag
//   I_NEG_EGDE    SCK falling-edge flag
//   I_MISO        serial data in
//   O_MOSI        serial data out (0 when not transferring)
//   O_GO          run request to the clock generator
//   O_LAST_CLK    final SCK period flag
//   O_RX_DATA     last completed received word
//   O_RX_VALID    one-cycle completion pulse
//   O_BUSY        transfer in progress
//
// Build option
//   SPI_SHIFTER_LOOPBACK_EN  when defined, the receive path samples the
//                            block's own O_MOSI and I_MISO is ignored.
module spi_shifter #(
  parameter int N = 8
) (
  input  logic         I_SYS_CLK,
  input  logic         I_RST,
  input  logic         I_EN,
  input  logic         I_CPOL,
  input  logic         I_CPHA,
  input  logic         I_LSB_FIRST,
  input  logic         I_START,
  input  logic [N-1:0] I_TX_DATA,
  input  logic         I_POS_EGDE,
  input  logic         I_NEG_EGDE,
  input  logic         I_MISO,
  output logic         O_MOSI,
  output logic         O_GO,
  output logic         O_LAST_CLK,
  output logic [N-1:0] O_RX_DATA,
  output logic         O_RX_VALID,
  output logic         O_BUSY
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic          cpol_q, cpha_q, lsb_q;
  logic          first_lead;
  logic [N-1:0]  tx_sr, rx_sr;
  logic [CW-1:0] cnt;

  logic          edge_ok, lead, trail, sample, shift, adv, rx_bit, mosi_nxt;
  logic [N-1:0]  rx_next, tx_shift;

`ifdef SPI_SHIFTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = I_MISO;
  assign rx_bit      = O_MOSI;
`else
  assign rx_bit      = I_MISO;
`endif

  // Coincident flags carry no usable edge information, so drop them.
  assign edge_ok = I_POS_EGDE ^ I_NEG_EGDE;
  assign lead    = edge_ok & (cpol_q ? I_NEG_EGDE : I_POS_EGDE);
  assign trail   = edge_ok & (cpol_q ? I_POS_EGDE : I_NEG_EGDE);
  assign sample  = cpha_q ? trail : lead;
  assign shift   = cpha_q ? lead  : trail;
  // With CPHA=1 the first bit is already on MOSI from the start cycle, so
  // the first leading edge must not advance it.
  assign adv     = shift & ~(cpha_q & first_lead);

  always_comb begin
    rx_next = rx_sr;
    if (sample) rx_next = lsb_q ? {rx_bit, rx_sr[N-1:1]} : {rx_sr[N-2:0], rx_bit};
  end

  assign tx_shift = lsb_q ? {1'b0, tx_sr[N-1:1]} : {tx_sr[N-2:0], 1'b0};
  assign mosi_nxt = lsb_q ? tx_sr[1] : tx_sr[N-2];

  always_ff @(posedge I_SYS_CLK) begin
    if (I_RST) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      first_lead <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cnt        <= '0;
      O_MOSI     <= 1'b0;
      O_GO       <= 1'b0;
      O_LAST_CLK <= 1'b0;
      O_RX_DATA  <= '0;
      O_RX_VALID <= 1'b0;
      O_BUSY     <= 1'b0;
    end else begin
      O_RX_VALID <= 1'b0;
      case (state)
        IDLE: begin
          O_MOSI <= 1'b0;
          if (I_START && I_EN) begin
            cpol_q     <= I_CPOL;
            cpha_q     <= I_CPHA;
            lsb_q      <= I_LSB_FIRST;
            first_lead <= 1'b1;
            tx_sr      <= I_TX_DATA;
            rx_sr      <= '0;
            cnt        <= CW'(N-1);
            O_MOSI     <= I_LSB_FIRST ? I_TX_DATA[0] : I_TX_DATA[N-1];
            O_GO       <= 1'b1;
            O_BUSY     <= 1'b1;
            O_LAST_CLK <= 1'b0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (!I_EN) begin
            O_GO       <= 1'b0;
            O_LAST_CLK <= 1'b0;
            O_BUSY     <= 1'b0;
            O_MOSI     <= 1'b0;
            state      <= IDLE;
          end else begin
            rx_sr <= rx_next;
            if (lead) first_lead <= 1'b0;
            if (adv) begin
              tx_sr  <= tx_shift;
              O_MOSI <= mosi_nxt;
            end
            if (trail) begin
              if (cnt == '0) begin
                // rx_next already holds the final sample when CPHA=1.
                O_RX_DATA  <= rx_next;
                O_RX_VALID <= 1'b1;
                O_GO       <= 1'b0;
                O_LAST_CLK <= 1'b0;
                O_BUSY     <= 1'b0;
                O_MOSI     <= 1'b0;
                state      <= DONE;
              end else begin
                cnt        <= cnt - 1'b1;
                O_LAST_CLK <= (cnt == CW'(1));
              end
            end
          end
        end
        DONE: begin
          O_MOSI <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter. The stimulus acts as both the SPI
// clock generator (edge flags) and the slave (drives MISO before each sample
// edge, checks MOSI at each sample edge). Expected received words go into a
// scoreboard queue when a transfer is issued; a monitor pops them on
// O_RX_VALID and also checks completion latency.
module tb_spi_shifter;
  localparam int N = 8;

  logic         clk = 1'b0, rst = 1'b1, en = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic         lsb = 1'b0, start = 1'b0, pos = 1'b0, neg = 1'b0, miso = 1'b0;
  logic [N-1:0] tx = '0;
  logic         mosi, go, last_clk, rx_valid, busy;
  logic [N-1:0] rx_data;

  spi_shifter #(.N(N)) dut (
    .I_SYS_CLK(clk), .I_RST(rst), .I_EN(en), .I_CPOL(cpol), .I_CPHA(cpha),
    .I_LSB_FIRST(lsb), .I_START(start), .I_TX_DATA(tx),
    .I_POS_EGDE(pos), .I_NEG_EGDE(neg), .I_MISO(miso),
    .O_MOSI(mosi), .O_GO(go), .O_LAST_CLK(last_clk), .O_RX_DATA(rx_data),
    .O_RX_VALID(rx_valid), .O_BUSY(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  logic [N-1:0] exp_q[$];
  int           exp_cyc[$];
  logic [N-1:0] last_rx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic edge_pulse(input logic p, input logic n);
    pos = p; neg = n;
    tick();
    pos = 1'b0; neg = 1'b0;
  endtask

  // Random idle gap, occasionally with an illegal both-flags cycle.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 3) == 0) edge_pulse(1'b1, 1'b1);
      else tick();
    end
  endtask

  // One transfer as seen from the bus. abort_k >= 0 drops I_EN before the
  // (abort_k+1)-th leading edge; hold keeps I_START high throughout.
  task automatic xfer(input logic [N-1:0] t, input logic [N-1:0] mw,
                      input logic pl, input logic ph, input logic lf,
                      input int abort_k, input bit hold);
    logic [N-1:0] exp_rx;
    int idx;
`ifdef SPI_SHIFTER_LOOPBACK_EN
    exp_rx = t;
`else
    exp_rx = mw;
`endif
    cpol = pl; cpha = ph; lsb = lf; tx = t; en = 1'b1; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    // Mode inputs may change freely once the transfer has started.
    cpol = 1'($urandom_range(0, 1));
    cpha = 1'($urandom_range(0, 1));
    lsb  = 1'($urandom_range(0, 1));
    tx   = N'($urandom);
    chk("go_after_start", 32'(go), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (abort_k < 0) exp_q.push_back(exp_rx);
    for (int k = 0; k < N; k++) begin
      idx = lf ? k : N - 1 - k;
      if (k == abort_k) begin
        en = 1'b0;
        tick();
        en = 1'b1;
        start = 1'b0;
        chk("abort_go", 32'(go), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(last_clk), 32'd0);
        chk("abort_rx_keep", 32'(rx_data), 32'(last_rx));
        return;
      end
      gap();
      if (!ph) begin
        miso = mw[idx];
        chk("mosi_bit", 32'(mosi), 32'(t[idx]));
      end
      chk("last_clk_lead", 32'(last_clk), 32'(k == N - 1));
      edge_pulse(!pl, pl);
      gap();
      if (ph) begin
        miso = mw[idx];
        chk("mosi_bit", 32'(mosi), 32'(t[idx]));
      end
      chk("last_clk_trail", 32'(last_clk), 32'(k == N - 1));
      if (k == N - 1) exp_cyc.push_back(cyc + 1);
      edge_pulse(pl, !pl);
    end
    // DONE cycle now; the monitor sees O_RX_VALID here.
    chk("done_mosi", 32'(mosi), 32'd0);
    chk("done_go", 32'(go), 32'd0);
    tick();
    start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    last_rx = exp_rx;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
      else begin
        chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        if (exp_cyc.size() == 0) chk("rx_latency_missing", 32'(rx_valid), 32'd0);
        else chk("rx_latency", 32'(cyc), 32'(exp_cyc.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_last", 32'(last_clk), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    en = 1'b1;
    tick();

    // Mode 0 MSB-first, then mode 3 LSB-first.
    xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    xfer(8'h81, 8'hF0, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    // Abort after three edge pairs.
    xfer(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    tick();

    // Reset mid-transfer, with START/EN high alongside it.
    tx = 8'h33; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    edge_pulse(1'b1, 1'b0); edge_pulse(1'b0, 1'b1); edge_pulse(1'b1, 1'b0);
    rst = 1'b1; start = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("midrst_mosi", 32'(mosi), 32'd0);
    chk("midrst_go", 32'(go), 32'd0);
    chk("midrst_last", 32'(last_clk), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    last_rx = '0;
    xfer(8'h55, N'($urandom), 1'b0, 1'b1, 1'b0, -1, 1'b0);

    // START held through XFER and DONE: one transfer only.
    xfer(8'hC3, 8'h96, 1'b1, 1'b0, 1'b0, -1, 1'b1);

    // Randomised transfers, some aborted.
    for (int r = 0; r < 24; r++) begin
      xfer(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, N - 1)) : -1,
           1'($urandom_range(0, 1)));
      tick();
    end

    // Edge flags while idle must do nothing.
    for (int i = 0; i < 6; i++) begin
      edge_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("idle_edge_mosi", 32'(mosi), 32'd0);
      chk("idle_edge_busy", 32'(busy), 32'd0);
    end

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
